pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer; successor to the single-width PC register.
//  - Sequences next-PC for sequential, branch, JAL and JALR flow.
//  - Adds trap entry/return with EPC/cause capture, a double-fault halt and target alignment checking.
//  - Sits between the control FSM (pc_write strobe) and instruction memory address port.
// PARAMETERS
//  XLEN         32            address/data width in bits (>=8)
//  RESET_VECTOR 32'h0000_0000 pc value loaded by rst
//  TRAP_VECTOR  32'h0000_0100 pc value loaded on trap entry
//  INC_BYTES    4             sequential increment in bytes
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous, active-high reset
//  pc_write     in   1     commit strobe; state/pc update only when 1
//  isBranch     in   1     conditional branch instruction
//  isJump       in   1     JAL instruction
//  isJALR       in   1     JALR instruction
//  take_branch  in   1     branch condition result
//  immed        in   XLEN  sign-extended immediate
//  rs1_data     in   XLEN  rs1 operand for JALR
//  trap_req     in   1     external/instruction trap request
//  trap_cause   in   4     cause code accompanying trap_req
//  mret         in   1     return-from-handler instruction
//  pc           out  XLEN  current pc (registered)
//  next_pc      out  XLEN  combinational value pc takes at next committed edge
//  epc          out  XLEN  saved pc of trapping instruction (registered)
//  cause        out  4     saved trap cause (registered)
//  in_handler   out  1     1 while FSM in HANDLER
//  halted       out  1     1 while FSM in HALT
//  redirect     out  1     registered 1-cycle pulse after any non-sequential pc update
//  misalign     out  1     combinational: selected redirect target misaligned
// BEHAVIOUR
//  Reset (async): pc=RESET_VECTOR, epc=0, cause=0, state=RUN, redirect=0; in_handler/halted=0.
//  Targets: br/jal = pc+immed; jalr = (rs1_data+immed) & ~1; seq = pc+INC_BYTES.
//   All sums modulo 2^XLEN, overflow/carry dropped (pc 'hFFFF_FFFC +4 -> 0).
//  Priority at committed edge (pc_write=1): trap_req > misalign > mret > (isJump|isBranch&take_branch) > isJALR > seq.
//  isBranch with take_branch=0 -> seq; no-op flags -> seq.
//  FSM states: RUN, HANDLER, HALT.
//   RUN + trap_req: epc<=pc, cause<=trap_cause, pc<=TRAP_VECTOR, ->HANDLER.
//   RUN + misalign: epc<=pc, cause<=4'h0, pc<=TRAP_VECTOR, ->HANDLER.
//   RUN + mret: illegal; epc<=pc, cause<=4'h2, pc<=TRAP_VECTOR, ->HANDLER.
//   HANDLER + trap_req or misalign: double fault; ->HALT; pc, epc, cause held.
//   HANDLER + mret: pc<=epc, ->RUN.
//   HANDLER otherwise: normal sequencing.
//   HALT: all inputs ignored, pc frozen, next_pc=pc; exit only via rst.
//  pc_write=0: no register changes in any state; next_pc still reflects inputs.
//  redirect=1 on the cycle after a committed edge that loaded a non-seq value:
//   branch/jal/jalr taken, trap entry or mret. Otherwise 0; never 1 in HALT.
//  Simultaneous flags: resolved strictly by the priority list; trap wins over mret.
//  rst asserted mid-operation: immediate return to reset values, regardless of pc_write.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//   - misalign = redirect taken & target[1:0]!=0 (trap, cause 0, target not loaded).
//  PC_ALIGN_CHECK_EN undefined:
//   - misalign tied 0; target[1:0] forced to 2'b00 before load.
//   - No alignment traps.
// TESTING
//  rst; pc_write=1 x3, no flags -> pc 0,4,8,C; redirect stays 0.
//  pc=8, isBranch=1, take_branch=1, immed=-8 -> pc=0, redirect=1 next cycle.
//   Same with take_branch=0 -> pc=C.
//  pc=10, isJALR, rs1=0x201, immed=2 -> pc=0x202.
//   EN: trap, epc=10, cause=0, pc=0x100. Not EN: pc=0x200.
//  pc=20, trap_req, cause=7 -> pc=0x100, epc=20, in_handler=1.
//   mret -> pc=20, in_handler=0.
//  In HANDLER: trap_req -> halted=1, pc frozen for 10 cycles of pc_write.
//   rst mid-run -> pc=RESET_VECTOR same edge.
//  mret in RUN at pc=30 -> cause=2, epc=30, pc=0x100.
//   pc=FFFFFFFC seq -> pc=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised next-PC sequencer with trap entry/return and double-fault halt.
// Define PC_ALIGN_CHECK_EN to trap on misaligned redirect targets instead of truncating them.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(256),
    parameter int unsigned     INC_BYTES    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            isBranch,
    input  logic            isJump,
    input  logic            isJALR,
    input  logic            take_branch,
    input  logic [XLEN-1:0] immed,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            trap_req,
    input  logic [3:0]      trap_cause,
    input  logic            mret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] epc,
    output logic [3:0]      cause,
    output logic            in_handler,
    output logic            halted,
    output logic            redirect,
    output logic            misalign
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] INC  = XLEN'(INC_BYTES);
    localparam logic [XLEN-1:0] BIT0 = XLEN'(1);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] epc_d;
    logic [3:0]      cause_q;
    logic [3:0]      cause_d;
    logic            redirect_q;
    logic            redir_d;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] flow_tgt;
    logic [XLEN-1:0] flow_load;
    logic            br_sel;
    logic            flow_sel;
    logic            tgt_mis;

    logic            in_run;
    logic            in_hdl;
    logic            ev_fault;
    logic            ev_mret;
    logic            ev_flow;
    logic            take_trap;
    logic            dbl_fault;
    logic            ret_run;
    logic            do_flow;
    logic            do_seq;

    assign seq_pc   = pc_q + INC;
    assign br_tgt   = pc_q + immed;
    assign jalr_tgt = (rs1_data + immed) & ~BIT0;
    assign br_sel   = isJump | (isBranch & take_branch);
    assign flow_sel = br_sel | isJALR;
    assign flow_tgt = br_sel ? br_tgt : jalr_tgt;

`ifdef PC_ALIGN_CHECK_EN
    assign tgt_mis   = flow_sel & (flow_tgt[1:0] != 2'b00);
    assign flow_load = flow_tgt;
`else
    localparam logic [XLEN-1:0] LOW2 = XLEN'(3);
    assign tgt_mis   = 1'b0;
    assign flow_load = flow_tgt & ~LOW2;
`endif

    assign in_run = (state_q == RUN);
    assign in_hdl = (state_q == HANDLER);

    // Priority: trap_req > misalign > mret > branch/jal > jalr > seq
    assign ev_fault  = trap_req | tgt_mis;
    assign ev_mret   = ~ev_fault & mret;
    assign ev_flow   = ~ev_fault & ~mret & flow_sel;
    assign take_trap = in_run & (ev_fault | ev_mret);
    assign dbl_fault = in_hdl & ev_fault;
    assign ret_run   = in_hdl & ev_mret;
    assign do_flow   = (in_run | in_hdl) & ev_flow;
    assign do_seq    = (in_run | in_hdl) & ~ev_fault & ~mret & ~flow_sel;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            cause_q    <= 4'h0;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= pc_write & redir_d;
            if (pc_write) begin
                state_q <= state_d;
                pc_q    <= next_pc;
                epc_q   <= epc_d;
                cause_q <= cause_d;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            take_trap: state_d = HANDLER;
            dbl_fault: state_d = HALT;
            ret_run:   state_d = RUN;
            default:   state_d = state_q;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        next_pc = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        redir_d = 1'b0;
        unique case (1'b1)
            take_trap: begin
                next_pc = TRAP_VECTOR;
                epc_d   = pc_q;
                redir_d = 1'b1;
                if (trap_req)
                    cause_d = trap_cause;
                else if (tgt_mis)
                    cause_d = 4'h0;
                else
                    cause_d = 4'h2;
            end
            dbl_fault: next_pc = pc_q;
            ret_run: begin
                next_pc = epc_q;
                redir_d = 1'b1;
            end
            do_flow: begin
                next_pc = flow_load;
                redir_d = 1'b1;
            end
            do_seq:  next_pc = seq_pc;
            default: next_pc = pc_q;
        endcase
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign cause      = cause_q;
    assign redirect   = redirect_q;
    assign in_handler = in_hdl;
    assign halted     = (state_q == HALT);
    assign misalign   = tgt_mis & ~halted;

endmodule
